// File: rtl/aes_pkg.sv
// Shared AES definitions used by both cipher directions:
// S-box table, Rcon, GF(2^8) xtime and the iterative-core FSM states.
package aes_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ROUND = 2'd1,
    DONE  = 2'd2
  } aes_fsm_e;

  localparam logic [0:255][7:0] SBOX_TABLE = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] x);
    return SBOX_TABLE[x];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction

  // Round constants for rounds 1..10; other indices never reach the key schedule.
  function automatic logic [7:0] rcon(input logic [3:0] cnt);
    logic [7:0] rc;
    case (cnt)
      4'd1:    rc = 8'h01;
      4'd2:    rc = 8'h02;
      4'd3:    rc = 8'h04;
      4'd4:    rc = 8'h08;
      4'd5:    rc = 8'h10;
      4'd6:    rc = 8'h20;
      4'd7:    rc = 8'h40;
      4'd8:    rc = 8'h80;
      4'd9:    rc = 8'h1b;
      4'd10:   rc = 8'h36;
      default: rc = 8'h00;
    endcase
    return rc;
  endfunction

endpackage

// File: rtl/aes_enc_round.sv
// One combinational AES encryption round: SubBytes, ShiftRows,
// MixColumns (skipped on the final round) and AddRoundKey.
module aes_enc_round
  import aes_pkg::*;
(
  input  logic [127:0] state,
  input  logic [127:0] round_key,
  input  logic         last,
  output logic [127:0] next_state
);

  logic [7:0] sb [16];
  logic [7:0] sr [16];
  logic [7:0] mc [16];

  always_comb begin
    for (int i = 0; i < 16; i++) sb[i] = sbox(state[127-8*i -: 8]);
  end

  // Byte i sits at row i%4, column i/4; row r rotates left by r columns.
  always_comb begin
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        sr[4*c+r] = sb[4*((c+r)%4)+r];
  end

  always_comb begin
    for (int c = 0; c < 4; c++) begin
      mc[4*c]   = xtime(sr[4*c]) ^ xtime(sr[4*c+1]) ^ sr[4*c+1] ^ sr[4*c+2] ^ sr[4*c+3];
      mc[4*c+1] = sr[4*c] ^ xtime(sr[4*c+1]) ^ xtime(sr[4*c+2]) ^ sr[4*c+2] ^ sr[4*c+3];
      mc[4*c+2] = sr[4*c] ^ sr[4*c+1] ^ xtime(sr[4*c+2]) ^ xtime(sr[4*c+3]) ^ sr[4*c+3];
      mc[4*c+3] = xtime(sr[4*c]) ^ sr[4*c] ^ sr[4*c+1] ^ sr[4*c+2] ^ xtime(sr[4*c+3]);
    end
  end

  always_comb begin
    for (int i = 0; i < 16; i++)
      next_state[127-8*i -: 8] = (last ? sr[i] : mc[i]) ^ round_key[127-8*i -: 8];
  end

endmodule

// File: rtl/aes_enc_iter.sv
// Iterative AES-128 encryption core: one round per clock, round keys
// derived on the fly, valid/ready handshakes on both sides.
module aes_enc_iter
  import aes_pkg::*;
#(
  parameter int NR = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] D_in,
  input  logic [127:0] key,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] D_out,
  output logic         busy
);

  generate
    if (NR != 10) begin : g_nr_check
      $error("aes_enc_iter: only NR=10 (AES-128) is supported");
    end
  endgenerate

  localparam logic [3:0] LAST_CNT = 4'(NR);

  aes_fsm_e     fsm;
  logic [127:0] st;
  logic [127:0] rk;
  logic [127:0] rk_next;
  logic [127:0] round_out;
  logic [127:0] d_out_q;
  logic [3:0]   cnt;
  logic         last;
  logic         accept;
  logic [31:0]  w0, w1, w2, w3, temp, n0, n1, n2, n3;

  assign in_ready = (fsm == IDLE) || (fsm == DONE && out_ready);
  assign accept   = in_valid && in_ready;
  assign busy     = (fsm == ROUND);
  assign last     = (cnt == LAST_CNT);
  assign D_out    = d_out_q;

  // Next round key from the current one: RotWord, SubWord, Rcon[cnt], then the XOR chain.
  assign {w0, w1, w2, w3} = rk;
  assign temp = {sbox(w3[23:16]), sbox(w3[15:8]), sbox(w3[7:0]), sbox(w3[31:24])}
                ^ {rcon(cnt), 24'h000000};
  assign n0 = w0 ^ temp;
  assign n1 = w1 ^ n0;
  assign n2 = w2 ^ n1;
  assign n3 = w3 ^ n2;
  assign rk_next = {n0, n1, n2, n3};

  aes_enc_round u_round (
    .state      (st),
    .round_key  (rk_next),
    .last       (last),
    .next_state (round_out)
  );

  // An accept overrides the DONE->IDLE move, giving back-to-back blocks with no gap.
  always_ff @(posedge clk) begin
    if (rst) begin
      fsm       <= IDLE;
      out_valid <= 1'b0;
      d_out_q   <= '0;
      cnt       <= '0;
      st        <= '0;
      rk        <= '0;
    end else begin
      case (fsm)
        IDLE: ;
        ROUND: begin
          st <= round_out;
          rk <= rk_next;
          if (last) begin
            d_out_q   <= round_out;
            out_valid <= 1'b1;
            fsm       <= DONE;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            fsm       <= IDLE;
          end
        end
        default: fsm <= IDLE;
      endcase
      if (accept) begin
        st  <= D_in ^ key;
        rk  <= key;
        cnt <= 4'd1;
        fsm <= ROUND;
      end
    end
  end

endmodule
